// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one outstanding memory read at a time,
// buffers returned words with their fetch PC in a small FIFO, reports
// misaligned fetch addresses as fault entries, and supports flush/redirect.
module instruction_fetch #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_addr,
  output logic            pc_advance,
  input  logic            flush,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_fault
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] req_pc_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;

  logic [XLEN-1:0] data_mem [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
  logic            fault_mem[FIFO_DEPTH];

  logic            push, pop, latch_pc;
  logic [XLEN-1:0] push_data, push_pc;
  logic            push_fault;
  logic [CW-1:0]   count_after_push;

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready & ~flush;
  assign mem_req     = (state_q == S_REQ);
  assign mem_addr    = (state_q == S_REQ) ? pc_addr : '0;

  // Head outputs are gated by valid so stale (unreset) storage never leaks out.
  assign instr       = instr_valid ? data_mem[rd_ptr_q]  : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q]    : '0;
  assign instr_fault = instr_valid ? fault_mem[rd_ptr_q] : 1'b0;

  // Occupancy after a response push, accounting for a same-cycle pop.
  assign count_after_push = count_q + CW'(1) - CW'(pop);

  // Next-state decode, FIFO push selection and the PC step pulse.
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_data  = '0;
    push_pc    = '0;
    push_fault = 1'b0;
    pc_advance = 1'b0;
    latch_pc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush && (count_q < DEPTH_C)) begin
          if (pc_addr[1:0] != 2'b00) begin
            push       = 1'b1;
            push_pc    = pc_addr;
            push_fault = 1'b1;
            state_d    = S_HALT;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flush) begin
          // A grant in the flush cycle still leaves a response in flight.
          state_d = mem_gnt ? S_DROP : S_IDLE;
        end else if (mem_gnt) begin
          pc_advance = 1'b1;
          latch_pc   = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            push      = 1'b1;
            push_data = mem_rdata;
            push_pc   = req_pc_q;
            state_d   = (count_after_push < DEPTH_C) ? S_REQ : S_IDLE;
          end
        end else if (flush) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (mem_rvalid) state_d = S_IDLE;
      end
      S_HALT: begin
        if (flush) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, request PC, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      req_pc_q <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_pc) req_pc_q <= pc_addr;
      if (flush) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        count_q <= count_q + CW'(push) - CW'(pop);
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Buffer storage; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q]  <= push_data;
      pc_mem[wr_ptr_q]    <= push_pc;
      fault_mem[wr_ptr_q] <= push_fault;
    end
  end

endmodule
